// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers for the single-clock FIFO
package sync_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Pointers and occupancy carry one extra bit so full and empty stay distinct
    function automatic int cnt_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port RAM, synchronous write, registered read
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WSIZE = 8,
    parameter int DSIZE = 32,
    localparam int AW = clog2(DSIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WSIZE-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WSIZE-1:0] rdata
);

    logic [WSIZE-1:0] mem [DSIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; array contents are left as they are
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO top; SYNC_FIFO_ERR_EN adds sticky overflow/underflow flags
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WSIZE    = 8,
    parameter int DSIZE    = 32,
    parameter int AF_LEVEL = DSIZE - 4,
    parameter int AE_LEVEL = 4,
    localparam int AW = clog2(DSIZE),
    localparam int CW = cnt_width(DSIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WSIZE-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [WSIZE-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam logic [CW-1:0] DEPTH_C = DSIZE[CW-1:0];
    localparam logic [CW-1:0] AF_C    = AF_LEVEL[CW-1:0];
    localparam logic [CW-1:0] AE_C    = AE_LEVEL[CW-1:0];
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic [CW-1:0] count_next;
    logic          wr_ok;
    logic          rd_ok;

    // A full FIFO still takes a write when a read frees the slot in the same edge
    assign wr_ok = we && (!full || re);
    assign rd_ok = re && !empty;

    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + ONE_C;
        end else if (rd_ok && !wr_ok) begin
            count_next = count - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE_C;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE_C;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
        end
    end

    sync_fifo_ram #(
        .WSIZE(WSIZE),
        .DSIZE(DSIZE)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok && rst),
        .waddr (wptr[AW-1:0]),
        .wdata (wdata),
        .re    (rd_ok),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

`ifdef SYNC_FIFO_ERR_EN
    // Set is evaluated after clear so a simultaneous event keeps the flag up
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (we && full && !re) begin
                overflow <= 1'b1;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed scoreboard bench for sync_fifo (SYNC_FIFO_ERR_EN optional)
module tb_sync_fifo;

    localparam int WSIZE = 8;
    localparam int DSIZE = 32;
    localparam int AF    = DSIZE - 4;
    localparam int AE    = 4;

    logic             clk;
    logic             rst;
    logic [WSIZE-1:0] wdata;
    logic             we;
    logic             re;
    logic [WSIZE-1:0] rdata;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [5:0]       count;
`ifdef SYNC_FIFO_ERR_EN
    logic             err_clr;
    logic             overflow;
    logic             underflow;
    logic             exp_ovf;
    logic             exp_unf;
`endif

    int               checks;
    int               failures;
    logic [WSIZE-1:0] model[$];
    logic [WSIZE-1:0] last_rdata;

    sync_fifo #(
        .WSIZE(WSIZE),
        .DSIZE(DSIZE),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wdata        (wdata),
        .we           (we),
        .re           (re),
        .rdata        (rdata),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = model.size();
        check({tag, ":rdata"}, 32'(rdata), 32'(last_rdata));
        check({tag, ":count"}, 32'(count), n);
        check({tag, ":empty"}, 32'(empty), 32'(n == 0));
        check({tag, ":full"}, 32'(full), 32'(n == DSIZE));
        check({tag, ":almost_full"}, 32'(almost_full), 32'(n >= AF));
        check({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE));
`ifdef SYNC_FIFO_ERR_EN
        check({tag, ":overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ":underflow"}, 32'(underflow), 32'(exp_unf));
`endif
    endtask

    // One clock edge of stimulus; the model decides acceptance from its own state
    task automatic step(input string tag, input logic w, input logic r, input logic [WSIZE-1:0] d);
        logic wr_ok;
        logic rd_ok;
        int   n;
        n = model.size();
        we    = w;
        re    = r;
        wdata = d;
        wr_ok = w && (n < DSIZE || r);
        rd_ok = r && (n != 0);
`ifdef SYNC_FIFO_ERR_EN
        if (err_clr) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end
        if (w && n == DSIZE && !r) exp_ovf = 1'b1;
        if (r && n == 0) exp_unf = 1'b1;
`endif
        @(posedge clk);
        #1;
        if (rd_ok) last_rdata = model.pop_front();
        if (wr_ok) model.push_back(d);
        we = 1'b0;
        re = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model.delete();
        last_rdata = '0;
`ifdef SYNC_FIFO_ERR_EN
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        we         = 1'b0;
        re         = 1'b0;
        wdata      = '0;
        last_rdata = '0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr    = 1'b0;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_reset();
        check_state("reset");

        for (int i = 0; i < DSIZE; i++) step("fill", 1'b1, 1'b0, 8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd32);

        step("write_when_full", 1'b1, 1'b0, 8'hEE);
        check("full_count_hold", 32'(count), 32'd32);

        for (int i = 0; i < DSIZE; i++) step("drain", 1'b0, 1'b1, 8'h00);
        check("drain_last", 32'(rdata), 32'h1F);
        check("drain_empty", 32'(empty), 32'd1);

        for (int i = 0; i < DSIZE; i++) step("refill", 1'b1, 1'b0, 8'(8'h40 + i));
        step("rw_full", 1'b1, 1'b1, 8'hAA);
        check("rw_full_count", 32'(count), 32'd32);
        check("rw_full_flag", 32'(full), 32'd1);
        check("rw_full_rdata", 32'(rdata), 32'h40);
        for (int i = 0; i < DSIZE; i++) step("drain_aa", 1'b0, 1'b1, 8'h00);
        check("aa_is_32nd", 32'(rdata), 32'hAA);

        step("rw_empty", 1'b1, 1'b1, 8'h55);
        check("rw_empty_rdata_held", 32'(rdata), 32'hAA);
        check("rw_empty_count", 32'(count), 32'd1);
        step("read_55", 1'b0, 1'b1, 8'h00);
        check("read_55_data", 32'(rdata), 32'h55);

        for (int i = 0; i < 10; i++) step("pre_reset", 1'b1, 1'b0, 8'(8'h90 + i));
        step("pre_reset_rd", 1'b0, 1'b1, 8'h00);
        do_reset();
        check_state("mid_reset");
        step("post_reset_wr", 1'b1, 1'b0, 8'h3C);
        step("post_reset_rd", 1'b0, 1'b1, 8'h00);
        check("post_reset_data", 32'(rdata), 32'h3C);

        for (int i = 0; i < 200; i++) begin
            step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        for (int i = 0; i < 40; i++) step("random_drain", 1'b0, 1'b1, 8'h00);

`ifdef SYNC_FIFO_ERR_EN
        do_reset();
        step("underflow_set", 1'b0, 1'b1, 8'h00);
        check("underflow_on", 32'(underflow), 32'd1);
        for (int i = 0; i < DSIZE; i++) step("err_fill", 1'b1, 1'b0, 8'(i));
        step("overflow_set", 1'b1, 1'b0, 8'h77);
        check("overflow_on", 32'(overflow), 32'd1);
        step("err_hold", 1'b0, 1'b0, 8'h00);
        err_clr = 1'b1;
        step("err_clear", 1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        check("overflow_off", 32'(overflow), 32'd0);
        check("underflow_off", 32'(underflow), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
